// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } arb_state_t;

   localparam logic [31:0] DEFAULT_DATA_BASE    = 32'h1001_0000;
   localparam int unsigned DEFAULT_MEMORY_DEPTH = 1024;

   // Debug wait bound is at most 255, so an 8-bit counter always suffices.
   localparam int unsigned WAIT_BOUND_MAX = 255;
   localparam int unsigned WAIT_CNT_WIDTH = $clog2(WAIT_BOUND_MAX + 1);

   typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_t;

endpackage

// File: rtl/dmem_addr_xlate.sv
// Byte address to memory word index translation with range check.
// Purely combinational; the low two address bits drop out in the shift.
module dmem_addr_xlate
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
   parameter logic [31:0] DATA_BASE    = DEFAULT_DATA_BASE
) (
   input  logic [31:0] addr,
   output logic [31:0] index,
   output logic        in_range
);

   // Modular subtraction: addresses below the base wrap to huge indexes.
   always_comb begin
      index    = (addr - DATA_BASE) >> 2;
      in_range = (index < 32'(MEMORY_DEPTH));
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage and a debug/loader port.
// Optional feature: define DMEM_ARB_FAIRNESS_EN to build the wait counter
// and the forced grant that stalls the CPU; without it the debug port is
// served only in CPU-idle cycles and cpu_stall is tied low.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
   parameter logic [31:0] DATA_BASE    = DEFAULT_DATA_BASE,
   parameter int unsigned MAX_WAIT     = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_mem_read,
   input  logic                  cpu_mem_write,
   input  logic [31:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   output logic                  cpu_fault,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [31:0]           dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_ack,
   output logic                  dbg_err,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   if (MAX_WAIT < 1 || MAX_WAIT > WAIT_BOUND_MAX) begin : g_bad_max_wait
      $error("dmem_arbiter: MAX_WAIT must be in 1..255");
   end

   arb_state_t  state;
   logic        cpu_access;
   logic        force_grant;
   logic        grant;
   logic [31:0] owner_addr;
   logic [31:0] owner_index;
   logic        owner_in_range;

   assign cpu_access = cpu_mem_read | cpu_mem_write;

`ifdef DMEM_ARB_FAIRNESS_EN
   wait_cnt_t wait_cnt;

   assign force_grant = (wait_cnt == wait_cnt_t'(MAX_WAIT));

   // Count debug wait cycles in IDLE, saturating at the bound.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (!dbg_req || grant) begin
         wait_cnt <= '0;
      end else if (state == IDLE && !force_grant) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   assign force_grant = 1'b0;
`endif

   // Grant is gated by reset so a grant cut short by reset never writes.
   assign grant = reset && (state == IDLE) && dbg_req && (!cpu_access || force_grant);

   dmem_addr_xlate #(
      .MEMORY_DEPTH (MEMORY_DEPTH),
      .DATA_BASE    (DATA_BASE)
   ) u_xlate (
      .addr     (owner_addr),
      .index    (owner_index),
      .in_range (owner_in_range)
   );

   // Memory port mux: debug owns it only in a grant cycle.
   always_comb begin
      owner_addr = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_write  = cpu_mem_write & owner_in_range;
      mem_read   = cpu_mem_read & owner_in_range;
      cpu_rdata  = owner_in_range ? mem_rdata : '0;
      if (grant) begin
         owner_addr = dbg_addr;
         mem_wdata  = dbg_wdata;
         mem_write  = dbg_we & owner_in_range;
         mem_read   = ~dbg_we & owner_in_range;
         cpu_rdata  = '0;
      end
      mem_addr = owner_index;
   end

`ifdef DMEM_ARB_FAIRNESS_EN
   assign cpu_stall = grant & cpu_access;
`else
   assign cpu_stall = 1'b0;
`endif

   // FSM with registered debug response and sticky CPU fault flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         dbg_ack   <= 1'b0;
         dbg_err   <= 1'b0;
         dbg_rdata <= '0;
         cpu_fault <= 1'b0;
      end else begin
         dbg_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  state     <= ACK;
                  dbg_ack   <= 1'b1;
                  dbg_err   <= ~owner_in_range;
                  dbg_rdata <= (owner_in_range && !dbg_we) ? mem_rdata : '0;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if (!grant && cpu_access && !owner_in_range) begin
            cpu_fault <= 1'b1;
         end
      end
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage and a debug/loader port. It translates MIPS byte addresses into memory word indexes and range-checks every access. It sits between the EX/MEM pipe outputs and the data memory instance. A configurable fairness guard can stall the pipeline so that a waiting debug request is guaranteed service.

## Interface
Parameters:
- DATA_WIDTH, 32: memory word width.
- MEMORY_DEPTH, 1024: number of memory words.
- DATA_BASE, 32'h1001_0000: byte address of word 0.
- MAX_WAIT, 8: debug wait cycles before the fairness guard forces a grant (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_mem_read  in  1  MEM-stage load.
- cpu_mem_write  in  1  MEM-stage store.
- cpu_addr  in  32  MEM-stage byte address (ALU result).
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data; combinational.
- cpu_stall  out  1  freezes PC and all pipe registers; combinational.
- cpu_fault  out  1  sticky flag: the CPU issued an out-of-range access.
- dbg_req  in  1  debug request; held high until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  32  debug byte address.
- dbg_wdata  in  DATA_WIDTH  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_err  out  1  valid with dbg_ack; the access was out of range.
- dbg_rdata  out  DATA_WIDTH  registered read data; valid with dbg_ack and held until the next ack.
- mem_addr  out  32  word index to the memory.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_rdata  in  DATA_WIDTH  memory read data; combinational in the same cycle.

## Operation
- The FSM has two states, IDLE and ACK.
- cpu_access = cpu_mem_read | cpu_mem_write.
- Address translation: word index = (addr − DATA_BASE) >> 2, using 32-bit modular subtraction.
- In range means index < MEMORY_DEPTH. Bits [1:0] of the address are ignored.
- Out-of-range accesses:
  - Force mem_write = 0 and mem_read = 0.
  - The owner sees read data = 0.
- A debug grant occurs in IDLE when dbg_req = 1 and either:
  - cpu_access = 0, or
  - wait_cnt == MAX_WAIT (fairness guard only).
- During a debug-grant cycle:
  - The memory port is muxed to the debug inputs.
  - If cpu_access = 1, cpu_stall = 1 and the CPU access is not performed.
  - The write commits at the closing edge; read data and dbg_err are captured into registers at the same edge.
  - The FSM moves to ACK.
- In ACK:
  - dbg_ack = 1 for exactly one cycle.
  - dbg_req is ignored.
  - The memory port belongs to the CPU.
  - The FSM returns to IDLE.
  - The requester must deassert dbg_req or present a new request in the cycle after ack.
- In all cycles without a debug grant, the CPU owns the port: mem_* carry the translated CPU signals and cpu_rdata = mem_rdata.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, in each IDLE cycle where dbg_req = 1 and the debug request is not granted.
  - Clears on a grant or when dbg_req = 0.
- cpu_fault sets on any CPU out-of-range access while the CPU owns the port. It is cleared only by reset.

## Timing
- Reset values:
  - State IDLE, wait_cnt 0.
  - dbg_ack 0, dbg_err 0, dbg_rdata 0, cpu_fault 0.
  - cpu_stall 0; the CPU owns the port.
- Debug latency: dbg_ack rises 1 cycle after the grant cycle. Minimum request-to-ack is 1 cycle.
- Worst-case request-to-ack with the fairness guard: MAX_WAIT + 1 cycles. Without the guard it is unbounded.
- A stall lasts exactly one cycle per debug grant.
- Reset asserted mid-operation:
  - In ACK, dbg_ack drops immediately (asynchronously) and no ack is replayed.
  - In a grant cycle, the write is not performed.
- A simultaneous CPU store and debug write in a forced-grant cycle: the debug write wins, and the CPU store is retried by the stalled pipeline on the following cycle.

## Configuration
- DMEM_ARB_FAIRNESS_EN defined:
  - wait_cnt and the forced grant are compiled in.
  - cpu_stall is driven as specified.
- Not defined:
  - The debug port is served only in CPU-idle cycles.
  - cpu_stall is tied to 0.
  - No counter is built.
  - The MAX_WAIT parameter is ignored.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACK);
  - the default DATA_BASE and MEMORY_DEPTH constants;
  - the wait-counter width, derived from the 8-bit bound.
- Sub-module dmem_addr_xlate, purely combinational, performs translation and range check. It is instantiated once, on the muxed (owner) address.

## Test plan
- CPU load from 0x1001_0008 with dbg_req = 0: mem_addr = 2, cpu_rdata = mem_rdata in the same cycle, cpu_stall = 0.
- dbg_req write of 0xDEAD_BEEF to 0x1001_0010 while the CPU is idle: mem_write = 1 with mem_addr = 4 in the grant cycle; dbg_ack = 1 with dbg_err = 0 on the next cycle.
- MAX_WAIT = 4, CPU accessing every cycle, dbg_req read held: the grant occurs on the 5th request cycle with cpu_stall = 1 for one cycle; dbg_ack follows one cycle later. With the macro off, no grant occurs until the CPU idles.
- CPU store to 0x1001_1000 (index 1024): mem_write = 0, cpu_fault sets and stays set; a debug read of 0x0000_0000 acks with dbg_err = 1 and dbg_rdata = 0.
- dbg_req held across ack: exactly one access is performed, and the next grant is no earlier than 2 cycles after the previous grant.
- reset asserted in ACK: dbg_ack falls immediately, and all registered outputs return to their reset values.
